// File: rtl/pipe_hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage pipeline: stall/flush
// generation for PC, IF/ID and ID/EX, multi-cycle op handshake, perf counters.
//
// state   | meaning
// IDLE    | normal flow; resolves jump > mc_req > load-use each cycle
// FLUSH   | IF/ID still being flushed after a taken jump
// MC_WAIT | pipeline frozen until multi-cycle done or timeout
module pipe_hazard_ctrl #(
    parameter int FLUSH_CYCLES = 2,
    parameter int MC_TIMEOUT   = 64,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1_addr_i,
    input  logic [4:0]       id_rs2_addr_i,
    input  logic             id_rs1_ren_i,
    input  logic             id_rs2_ren_i,
    input  logic [4:0]       ex_rd_addr_i,
    input  logic             ex_reg_wen_i,
    input  logic             ex_is_load_i,
    input  logic             ex_jump_en_i,
    input  logic             ex_mc_req_i,
    input  logic             ex_mc_done_i,
    output logic             stall_pc_o,
    output logic             stall_if_id_o,
    output logic             stall_id_ex_o,
    output logic             flush_if_id_o,
    output logic             flush_id_ex_o,
    output logic             mc_start_o,
    output logic             mc_err_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    localparam int TW = $clog2(MC_TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, FLUSH, MC_WAIT} state_t;

    state_t           state_q, state_d;
    logic [2:0]       fcnt_q, fcnt_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
    logic             jump_acc;
    logic             lu;
    logic             st_pc, st_ifid, st_idex, fl_ifid, fl_idex, mc_start;

    assign lu = ex_is_load_i && ex_reg_wen_i && (ex_rd_addr_i != 5'd0) &&
                ((id_rs1_ren_i && (id_rs1_addr_i == ex_rd_addr_i)) ||
                 (id_rs2_ren_i && (id_rs2_addr_i == ex_rd_addr_i)));

    always_comb begin
        state_d  = state_q;
        fcnt_d   = fcnt_q;
        timer_d  = timer_q;
        err_d    = err_q;
        jump_acc = 1'b0;
        st_pc    = 1'b0;
        st_ifid  = 1'b0;
        st_idex  = 1'b0;
        fl_ifid  = 1'b0;
        fl_idex  = 1'b0;
        mc_start = 1'b0;
        case (state_q)
            IDLE: begin
                if (ex_jump_en_i) begin
                    fl_ifid  = 1'b1;
                    fl_idex  = 1'b1;
                    jump_acc = 1'b1;
                    if (FLUSH_CYCLES > 1) begin
                        state_d = FLUSH;
                        fcnt_d  = 3'(FLUSH_CYCLES - 1);
                    end
                end else if (ex_mc_req_i) begin
                    st_pc    = 1'b1;
                    st_ifid  = 1'b1;
                    st_idex  = 1'b1;
                    mc_start = 1'b1;
                    state_d  = MC_WAIT;
                    timer_d  = '0;
                end else if (lu) begin
                    st_pc   = 1'b1;
                    st_ifid = 1'b1;
                    fl_idex = 1'b1;
                end
            end
            FLUSH: begin
                fl_ifid = 1'b1;
                if (ex_jump_en_i) begin
                    fl_idex  = 1'b1;
                    jump_acc = 1'b1;
                    fcnt_d   = 3'(FLUSH_CYCLES - 1);
                end else begin
                    fcnt_d = fcnt_q - 3'd1;
                    if (fcnt_q == 3'd1) state_d = IDLE;
                end
            end
            MC_WAIT: begin
                st_pc   = 1'b1;
                st_ifid = 1'b1;
                st_idex = 1'b1;
                timer_d = timer_q + TW'(1);
                // A done arriving on the timeout cycle completes normally.
                if (ex_mc_done_i) begin
                    state_d = IDLE;
                end else if (timer_q == TW'(MC_TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign stall_pc_o    = st_pc;
    assign stall_if_id_o = st_ifid;
    assign stall_id_ex_o = st_idex;
    assign flush_if_id_o = fl_ifid & ~st_ifid;
    assign flush_id_ex_o = fl_idex & ~st_idex;
    assign mc_start_o    = mc_start;
    assign mc_err_o      = err_q;
    assign stall_cnt_o   = stall_cnt_q;
    assign flush_cnt_o   = flush_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            fcnt_q      <= 3'd0;
            timer_q     <= '0;
            err_q       <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
            timer_q <= timer_d;
            err_q   <= err_d;
            if (st_pc)    stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            if (jump_acc) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed scenarios plus random
// traffic, checked against a cycle-level behavioural model.
module tb_pipe_hazard_ctrl;

    localparam int FC  = 2;
    localparam int MCT = 8;
    localparam int CW  = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic [4:0]    rs1, rs2, rd;
    logic          ren1, ren2, wen, is_load, jump, req, done;
    logic          stall_pc, stall_if_id, stall_id_ex, flush_if_id, flush_id_ex;
    logic          mc_start, mc_err;
    logic [CW-1:0] stall_cnt, flush_cnt;

    pipe_hazard_ctrl #(.FLUSH_CYCLES(FC), .MC_TIMEOUT(MCT), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .id_rs1_addr_i(rs1), .id_rs2_addr_i(rs2),
        .id_rs1_ren_i(ren1), .id_rs2_ren_i(ren2),
        .ex_rd_addr_i(rd), .ex_reg_wen_i(wen), .ex_is_load_i(is_load),
        .ex_jump_en_i(jump), .ex_mc_req_i(req), .ex_mc_done_i(done),
        .stall_pc_o(stall_pc), .stall_if_id_o(stall_if_id), .stall_id_ex_o(stall_id_ex),
        .flush_if_id_o(flush_if_id), .flush_id_ex_o(flush_id_ex),
        .mc_start_o(mc_start), .mc_err_o(mc_err),
        .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [6:0]    ctrl;
        logic [CW-1:0] sc;
        logic [CW-1:0] fc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Model state: remaining flush-only cycles, multi-cycle wait progress.
    int            flush_left;
    bit            in_mc;
    int            waited;
    bit            m_err;
    logic [CW-1:0] m_sc, m_fc;

    task automatic model_reset();
        flush_left = 0;
        in_mc      = 0;
        waited     = 0;
        m_err      = 0;
        m_sc       = '0;
        m_fc       = '0;
    endtask

    task automatic idle_inputs();
        rst = 0; rs1 = 0; rs2 = 0; rd = 0; ren1 = 0; ren2 = 0;
        wen = 0; is_load = 0; jump = 0; req = 0; done = 0;
    endtask

    task automatic step();
        exp_t e;
        bit sp = 0, si = 0, se = 0, fi = 0, fe = 0, ms = 0;
        bit hazard;
        hazard = is_load && wen && (rd != 0) &&
                 ((ren1 && rs1 == rd) || (ren2 && rs2 == rd));
        e.sc = m_sc;
        e.fc = m_fc;
        e.ctrl[0] = m_err;
        if (in_mc) begin
            sp = 1; si = 1; se = 1;
            waited++;
            if (done) in_mc = 0;
            else if (waited == MCT) begin
                m_err = 1;
                in_mc = 0;
            end
        end else if (flush_left > 0) begin
            fi = 1;
            if (jump) begin
                fe = 1;
                flush_left = FC - 1;
                m_fc++;
            end else begin
                flush_left--;
            end
        end else if (jump) begin
            fi = 1; fe = 1;
            flush_left = FC - 1;
            m_fc++;
        end else if (req) begin
            sp = 1; si = 1; se = 1; ms = 1;
            in_mc  = 1;
            waited = 0;
        end else if (hazard) begin
            sp = 1; si = 1; fe = 1;
        end
        if (sp) m_sc++;
        e.ctrl[6:1] = {sp, si, se, fi, fe, ms};
        if (rst) model_reset();
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if ({stall_pc, stall_if_id, stall_id_ex, flush_if_id, flush_id_ex, mc_start, mc_err} !== e.ctrl) begin
                errors++;
                $display("FAIL ctrl t=%0t got=%b expected=%b", $time,
                         {stall_pc, stall_if_id, stall_id_ex, flush_if_id, flush_id_ex, mc_start, mc_err}, e.ctrl);
            end
            checks++;
            if (stall_cnt !== e.sc) begin
                errors++;
                $display("FAIL stall_cnt t=%0t got=%0d expected=%0d", $time, stall_cnt, e.sc);
            end
            checks++;
            if (flush_cnt !== e.fc) begin
                errors++;
                $display("FAIL flush_cnt t=%0t got=%0d expected=%0d", $time, flush_cnt, e.fc);
            end
        end
    end

    initial begin
        idle_inputs();
        rst = 1;
        @(posedge clk);
        #1;
        model_reset();
        step();
        rst = 0;
        repeat (2) step();

        // load-use on rs2, then the rd=0 variant
        is_load = 1; wen = 1; rd = 5; rs2 = 5; ren2 = 1;
        step();
        idle_inputs();
        step();
        is_load = 1; wen = 1; rd = 0; rs2 = 0; ren2 = 1;
        step();
        idle_inputs();
        step();

        jump = 1;
        step();
        jump = 0;
        repeat (3) step();

        jump = 1; is_load = 1; wen = 1; rd = 7; rs1 = 7; ren1 = 1;
        step();
        idle_inputs();
        repeat (3) step();

        // multi-cycle op with done five cycles after the request
        req = 1;
        repeat (5) step();
        done = 1;
        step();
        idle_inputs();
        repeat (2) step();

        // timeout: request cycle plus MCT wait cycles
        req = 1;
        repeat (MCT + 1) step();
        req = 0;
        repeat (3) step();

        // reset while waiting
        req = 1;
        repeat (3) step();
        req = 0; rst = 1;
        step();
        rst = 0;
        repeat (2) step();

        for (int i = 0; i < 2000; i++) begin
            rst     = ($urandom_range(99) < 2);
            jump    = ($urandom_range(99) < 12);
            req     = ($urandom_range(99) < 20);
            done    = ($urandom_range(99) < 15);
            is_load = ($urandom_range(99) < 50);
            wen     = ($urandom_range(99) < 70);
            rd      = 5'($urandom_range(3));
            rs1     = 5'($urandom_range(3));
            rs2     = 5'($urandom_range(3));
            ren1    = ($urandom_range(99) < 60);
            ren2    = ($urandom_range(99) < 60);
            step();
        end

        idle_inputs();
        step();
        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d expected=0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
